// File: rtl/ncl_th_gate_bank_if.sv
// Input/output bundle for the NCL threshold gate bank.
// Lane i of each vector belongs to lane i of the bank.
interface ncl_th_gate_bank_if #(
    parameter int WIDTH = 1
);
    logic [4*WIDTH-1:0] a14;
    logic [2*WIDTH-1:0] a22;
    logic [3*WIDTH-1:0] a33;
    logic [WIDTH-1:0]   y14;
    logic [WIDTH-1:0]   y22;
    logic [WIDTH-1:0]   y33;

    modport master (
        output a14, a22, a33,
        input  y14, y22, y33
    );

    modport slave (
        input  a14, a22, a33,
        output y14, y22, y33
    );
endinterface

// File: rtl/ncl_th_gate_bank.sv
// Clocked NCL threshold gates (TH14, TH22, TH33) with flop-held hysteresis,
// replicated over WIDTH independent lanes.
module ncl_thmn #(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         init_n,
    input  logic [N-1:0] a,
    output logic         q
);
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt;
    logic          set_hit;
    logic          clr_hit;
    logic          q_next;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(a[i]);
        end
    end

    assign set_hit = (cnt >= CW'(M));
    assign clr_hit = ~|a;

    // Set and clear never overlap since M >= 1; neither means hold.
    always_comb begin
        q_next = q;
        unique case (1'b1)
            set_hit: q_next = 1'b1;
            clr_hit: q_next = 1'b0;
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            q <= 1'b0;
        end else begin
            q <= q_next;
        end
    end
endmodule

module ncl_th_gate_bank #(
    parameter int WIDTH = 1
) (
    input  logic                clk,
    input  logic                init_n,
    ncl_th_gate_bank_if.slave   bus
);
    logic [WIDTH-1:0] q14;
    logic [WIDTH-1:0] q22;
    logic [WIDTH-1:0] q33;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ncl_thmn #(.N(4), .M(1)) u_th14 (
            .clk    (clk),
            .init_n (init_n),
            .a      (bus.a14[4*i +: 4]),
            .q      (q14[i])
        );

        ncl_thmn #(.N(2), .M(2)) u_th22 (
            .clk    (clk),
            .init_n (init_n),
            .a      (bus.a22[2*i +: 2]),
            .q      (q22[i])
        );

        ncl_thmn #(.N(3), .M(3)) u_th33 (
            .clk    (clk),
            .init_n (init_n),
            .a      (bus.a33[3*i +: 3]),
            .q      (q33[i])
        );
    end

    assign bus.y14 = q14;
    assign bus.y22 = q22;
    assign bus.y33 = q33;
endmodule

// File: tb/tb_ncl_th_gate_bank.sv
// Directed-vector bench for ncl_th_gate_bank: one WIDTH=1 bank,
// one WIDTH=4 bank wired as a quad-rail link with TH14 completion.
module tb_ncl_th_gate_bank;
    logic clk = 1'b0;
    logic init_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ncl_th_gate_bank_if #(.WIDTH(1)) bus1 ();
    ncl_th_gate_bank_if #(.WIDTH(4)) bus4 ();

    ncl_th_gate_bank #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus1.slave)
    );

    ncl_th_gate_bank #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus4.slave)
    );

    // TH14 lane 0 is the completion detector over the four TH33 outputs.
    assign bus4.a14 = {12'b0, bus4.y33};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] v22 [5];
    logic       e22 [5];
    logic [2:0] v33 [6];
    logic       e33 [6];
    logic [3:0] v14 [5];
    logic       e14 [5];

    initial begin
        v22 = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        e22 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        v33 = '{3'b000, 3'b011, 3'b111, 3'b101, 3'b001, 3'b000};
        e33 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        v14 = '{4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b1111};
        e14 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        bus1.a14 = '1;
        bus1.a22 = '1;
        bus1.a33 = '1;
        bus4.a22 = '0;
        bus4.a33 = '0;

        // Reset held with all inputs high
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_y14_%0d", k), 32'(bus1.y14), 32'd0);
            check($sformatf("rst_y22_%0d", k), 32'(bus1.y22), 32'd0);
            check($sformatf("rst_y33_%0d", k), 32'(bus1.y33), 32'd0);
            step();
        end
        check("rst_w4_y22", 32'(bus4.y22), 32'd0);
        init_n = 1'b1;
        step();
        check("rel_y14", 32'(bus1.y14), 32'd1);
        check("rel_y22", 32'(bus1.y22), 32'd1);
        check("rel_y33", 32'(bus1.y33), 32'd1);

        // TH22 hysteresis
        for (int k = 0; k < 5; k++) begin
            bus1.a22 = v22[k];
            step();
            check($sformatf("th22_%0d", k), 32'(bus1.y22), 32'(e22[k]));
        end

        // TH33 hysteresis
        for (int k = 0; k < 6; k++) begin
            bus1.a33 = v33[k];
            step();
            check($sformatf("th33_%0d", k), 32'(bus1.y33), 32'(e33[k]));
        end

        // TH14
        for (int k = 0; k < 5; k++) begin
            bus1.a14 = v14[k];
            step();
            check($sformatf("th14_%0d", k), 32'(bus1.y14), 32'(e14[k]));
        end

        // Quat link: lane 0 TH33 = {en, bin0, tri0}, TH22 = {en, bin0}
        bus4.a33 = 12'b111;
        bus4.a22 = 8'b11;
        step();
        check("quat_set_y33", 32'(bus4.y33), 32'h1);
        check("quat_set_y22", 32'(bus4.y22), 32'h1);
        step();
        check("quat_set_cmp", 32'(bus4.y14), 32'h1);
        bus4.a33 = 12'b011;
        bus4.a22 = 8'b01;
        step();
        step();
        check("quat_hold_y33", 32'(bus4.y33), 32'h1);
        check("quat_hold_y22", 32'(bus4.y22), 32'h1);
        check("quat_hold_cmp", 32'(bus4.y14), 32'h1);
        bus4.a33 = '0;
        bus4.a22 = '0;
        step();
        check("quat_clr_y33", 32'(bus4.y33), 32'h0);
        check("quat_clr_y22", 32'(bus4.y22), 32'h0);
        step();
        check("quat_clr_cmp", 32'(bus4.y14), 32'h0);

        // Multi-lane: lane 2 only, then hold, then async reset mid-cycle
        bus4.a22 = 8'b0011_0000;
        step();
        check("lane2_set", 32'(bus4.y22), 32'h4);
        check("lane2_y33", 32'(bus4.y33), 32'h0);
        bus4.a22 = 8'b0001_0000;
        step();
        check("lane2_hold", 32'(bus4.y22), 32'h4);
        bus1.a14 = 4'b0001;
        step();
        check("pre_rst_y14", 32'(bus1.y14), 32'h1);
        #2;
        init_n = 1'b0;
        #1;
        check("async_rst_y22", 32'(bus4.y22), 32'h0);
        check("async_rst_y14", 32'(bus1.y14), 32'h0);
        step();
        check("rst_stays_y22", 32'(bus4.y22), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ncl_th_gate_bank.md
# ncl_th_gate_bank

Clocked bank of NCL threshold gates with hysteresis: TH14 (1-of-4), TH22 (2-of-2 C-element) and TH33 (3-of-3 C-element), replicated over `WIDTH` independent lanes. It is the gate-level primitive set for the quad-rail output links and completion detectors in the NCL sandbox, e.g. the binary+trinary→quaternary adder's output link and its `TH14` auto-consume completion. The hysteresis state is held in flops so the gates simulate and synthesize deterministically under a single clock.

## Interface
Parameters:
- `WIDTH`, default 1: number of independent lanes; each lane contains one TH14, one TH22 and one TH33.

Ports:
- `clk`, input, 1: single clock; all gate state updates on the rising edge.
- `init_n`, input, 1: reset, asynchronous, active-low. Drives every gate to NULL (0).
- `a14`, input, 4*WIDTH: TH14 inputs; lane i uses bits [4i+3:4i].
- `a22`, input, 2*WIDTH: TH22 inputs; lane i uses bits [2i+1:2i].
- `a33`, input, 3*WIDTH: TH33 inputs; lane i uses bits [3i+2:3i].
- `y14`, output, WIDTH: TH14 gate outputs, one per lane.
- `y22`, output, WIDTH: TH22 gate outputs, one per lane.
- `y33`, output, WIDTH: TH33 gate outputs, one per lane.

## Operation
Each gate is a one-bit state flop q with the threshold rule below, evaluated every rising `clk` edge:
- Generic THmn rule: q' = 1 if at least m of its n inputs are 1 (set); q' = 0 if all n inputs are 0 (clear); otherwise q' = q (hold/hysteresis).
- TH14 (m=1, n=4): q' = OR of the 4 inputs. The hold case cannot occur, so the gate has no effective hysteresis.
- TH22 (m=2, n=2): set on 11, clear on 00, hold on 01/10.
- TH33 (m=3, n=3): set on 111, clear on 000, hold on any mixed pattern.
- Set and clear are mutually exclusive because n ≥ m ≥ 1, so no priority rule is needed.
- Lanes and gate types are fully independent. There is no cross-lane logic.
- Outputs come directly from the state flops. No combinational path exists from any input to any output.
- X/Z on inputs is not handled. The bench drives only 0/1.

## Timing
- Reset: while `init_n` = 0, all `y14`/`y22`/`y33` bits are 0 immediately (asynchronous) and stay 0 regardless of `clk` or inputs.
- Reset release: the first rising `clk` edge after `init_n` rises evaluates the rule with q = 0. A held mixed pattern therefore yields 0.
- Latency: an input change that is stable before rising edge k is reflected on the outputs after edge k (1 cycle).
- Inputs changing within the same cycle are sampled together. Only the pattern present at the edge matters; glitches between edges are ignored.
- Reset asserted mid-operation forces all outputs to 0 at once, whatever state they hold. Hold state is lost.
- NCL handshake discipline (DATA wavefront, then NULL wavefront) is the user's responsibility. The bank only applies the threshold rules per cycle.

## Test plan
1. Reset: `init_n` = 0 with all inputs at 1, toggle `clk` → `y14` = `y22` = `y33` = 0 throughout. Release `init_n` with inputs still at 1 → all outputs 1 after the next edge.
2. TH22 hysteresis, WIDTH=1: apply `a22` = 00, 01, 11, 10, 00 on successive edges → `y22` = 0, 0, 1, 1, 0, each one cycle after its input.
3. TH33 hysteresis: apply `a33` = 000, 011, 111, 101, 001, 000 → `y33` = 0, 0, 1, 1, 1, 0.
4. TH14: apply `a14` = 0000, 0100, 1000, 0000, 1111 → `y14` = 0, 1, 1, 0, 1.
5. Quat link pattern (TH33 with enable input, TH22 with enable): with enable = 1, drive binary[0] = trinary[0] = 1 → TH33 = 1 and the TH14 completion over the four link outputs = 1. Then drop enable only → both hold 1. Then drop all inputs → both 0.
6. Multi-lane, WIDTH=4: set only lane 2 inputs (`a22`[5:4] = 11) → `y22` = 4'b0100, other lanes 0. Assert `init_n` = 0 mid-hold → all outputs 0 without waiting for `clk`.
